// File: rtl/keypad_scanner_if.sv
// Keypad-side and key-event signals of keypad_scanner, bundled for the scanner
// and its consumer.
interface keypad_scanner_if;
    // key_valid is a one-cycle strobe with no back-pressure; key_code is valid
    // with it and holds its value until the next accepted key.
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [1:0] state;

    modport slave (
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_held,
        output state
    );

    modport master (
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_held,
        input  state
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column-at-a-time scan, full-scan debounce,
// one hex key code per press.
module keypad_scanner #(
    parameter int SCAN_TICKS     = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input logic            clk,
    input logic            reset,
    keypad_scanner_if.slave kp
);
    localparam int TW = $clog2(SCAN_TICKS);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED} state_t;

    logic [3:0]    row_meta, row_sync;
    logic [TW-1:0] tick;
    logic [1:0]    col_idx;
    logic [15:0]   snap;       // bit c*4+r set = key at row r / column c pressed
    logic [15:0]   snap_full;
    logic          tick_last, scan_done;

    state_t        state, state_n;
    logic [3:0]    cand, cand_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    code, code_n;
    logic          held, held_n;
    logic          valid, valid_n;

    logic          found, multi, single, none;
    logic [3:0]    k;

    function automatic logic [3:0] key_map(input logic [3:0] idx);
        case (idx)
            4'd0:  key_map = 4'h1;  4'd1:  key_map = 4'h4;
            4'd2:  key_map = 4'h7;  4'd3:  key_map = 4'h0;
            4'd4:  key_map = 4'h2;  4'd5:  key_map = 4'h5;
            4'd6:  key_map = 4'h8;  4'd7:  key_map = 4'hF;
            4'd8:  key_map = 4'h3;  4'd9:  key_map = 4'h6;
            4'd10: key_map = 4'h9;  4'd11: key_map = 4'hE;
            4'd12: key_map = 4'hA;  4'd13: key_map = 4'hB;
            4'd14: key_map = 4'hC;  default: key_map = 4'hD;
        endcase
    endfunction

    assign tick_last = (tick == TW'(SCAN_TICKS - 1));
    assign scan_done = tick_last && (col_idx == 2'd3);
    assign kp.col    = ~(4'b0001 << col_idx);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
            tick     <= '0;
            col_idx  <= 2'd0;
            snap     <= '0;
        end else begin
            row_meta <= kp.row;
            row_sync <= row_meta;
            if (tick_last) begin
                tick                       <= '0;
                col_idx                    <= col_idx + 2'd1;
                snap[{col_idx, 2'b00} +: 4] <= ~row_sync;
            end else begin
                tick <= tick + TW'(1);
            end
        end
    end

    // The column-3 slice is being latched on scan done, so classify with it folded in.
    assign snap_full = {~row_sync, snap[11:0]};

    always_comb begin
        found = 1'b0;
        multi = 1'b0;
        k     = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (snap_full[i]) begin
                if (found) multi = 1'b1;
                found = 1'b1;
                k     = key_map(4'(i));
            end
        end
        single = found && !multi;
        none   = !found;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cand  <= 4'h0;
            cnt   <= '0;
            code  <= 4'h0;
            held  <= 1'b0;
            valid <= 1'b0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            cnt   <= cnt_n;
            code  <= code_n;
            held  <= held_n;
            valid <= valid_n;
        end
    end

    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        code_n  = code;
        held_n  = held;
        valid_n = 1'b0;
        if (scan_done) begin
            case (state)
                IDLE: begin
                    if (single) begin
                        cand_n  = k;
                        cnt_n   = CW'(1);
                        state_n = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (single && (k == cand)) begin
                        if (cnt == CW'(DEBOUNCE_SCANS - 1)) begin
                            state_n = PRESSED;
                            valid_n = 1'b1;
                            code_n  = cand;
                            held_n  = 1'b1;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end else if (single) begin
                        cand_n = k;
                        cnt_n  = CW'(1);
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                PRESSED: begin
                    if (none) begin
                        if (cnt == CW'(DEBOUNCE_SCANS - 1)) begin
                            state_n = IDLE;
                            held_n  = 1'b0;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end else begin
                        cnt_n = '0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign kp.key_code  = code;
    assign kp.key_valid = valid;
    assign kp.key_held  = held;
    assign kp.state     = state;
endmodule
